// File: rtl/vtp_fail_log_fifo.sv
`timescale 1ns/1ps
// Purpose : in-order log of VTP read/write translation failures (VA, channel, sequence number),
//           with a saturating count of events lost to a full log.
// Latency : push-to-visible 1 cycle; show-ahead head; a pop removes the head at the clock edge.
// Backpress: none upstream; events arriving while the log is full are dropped and counted.
// Ports   : clk/reset (async, active-high); rd_/wr_fail_valid + _va event inputs; clear (sync flush);
//           log_rd_en pops the head; log_valid/log_va/log_is_wr/log_seq show the head;
//           log_count = occupancy; drop_cnt = saturating count of lost events.
module vtp_fail_log_fifo #(
  parameter int DEPTH     = 16,
  parameter int VA_WIDTH  = 64,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rd_fail_valid,
  input  logic [VA_WIDTH-1:0]      rd_fail_va,
  input  logic                     wr_fail_valid,
  input  logic [VA_WIDTH-1:0]      wr_fail_va,
  input  logic                     clear,
  input  logic                     log_rd_en,
  output logic                     log_valid,
  output logic [VA_WIDTH-1:0]      log_va,
  output logic                     log_is_wr,
  output logic [CNT_WIDTH-1:0]     log_seq,
  output logic [$clog2(DEPTH):0]   log_count,
  output logic [CNT_WIDTH-1:0]     drop_cnt
);

  localparam int AW  = $clog2(DEPTH);
  localparam int OW  = AW + 1;
  localparam int CW1 = CNT_WIDTH + 1;

  typedef struct packed {
    logic [VA_WIDTH-1:0]  va;
    logic                 is_wr;
    logic [CNT_WIDTH-1:0] seq;
  } entry_t;

  entry_t               mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]        occ_q, occ_d;
  logic [CNT_WIDTH-1:0] seq_q, seq_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;

  logic                 pop_ok;
  logic                 rd_push, wr_push;
  logic [OW-1:0]        free_slots;
  logic [OW-1:0]        n_push;
  logic [CW1-1:0]       n_drop;
  logic [CW1-1:0]       drop_sum;
  logic [AW-1:0]        wr_slot;
  entry_t               rd_entry, wr_entry, head;

  always_comb begin
    pop_ok     = log_rd_en && (occ_q != '0) && !clear;
    // A same-cycle pop frees its slot for this cycle's pushes; cannot exceed DEPTH
    // because a pop implies at least one occupied slot.
    free_slots = OW'(DEPTH) - occ_q + OW'(pop_ok);
    rd_push    = !clear && rd_fail_valid && (free_slots != '0);
    // wr needs one slot beyond whatever rd consumed (rd valid but dropped means free is 0).
    wr_push    = !clear && wr_fail_valid && (free_slots > OW'(rd_fail_valid));
    n_push     = OW'(rd_push) + OW'(wr_push);
    n_drop     = clear ? '0 : (CW1'(rd_fail_valid & ~rd_push) + CW1'(wr_fail_valid & ~wr_push));
    drop_sum   = {1'b0, drop_q} + n_drop;
    wr_slot    = wr_ptr_q + AW'(rd_push);

    rd_entry.va    = rd_fail_va;
    rd_entry.is_wr = 1'b0;
    rd_entry.seq   = seq_q;
    wr_entry.va    = wr_fail_va;
    wr_entry.is_wr = 1'b1;
    // wr is numbered after rd whether or not rd was admitted.
    wr_entry.seq   = seq_q + CNT_WIDTH'(rd_fail_valid);

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      seq_d    = '0;
      drop_d   = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(n_push);
      rd_ptr_d = rd_ptr_q + AW'(pop_ok);
      occ_d    = occ_q + n_push - OW'(pop_ok);
      seq_d    = seq_q + CNT_WIDTH'(rd_fail_valid) + CNT_WIDTH'(wr_fail_valid);
      drop_d   = drop_sum[CW1-1] ? '1 : drop_sum[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      seq_q    <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      seq_q    <= seq_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: outputs are gated by occupancy, so stale slots are never visible.
  always_ff @(posedge clk) begin
    if (rd_push) mem_q[wr_ptr_q] <= rd_entry;
    if (wr_push) mem_q[wr_slot]  <= wr_entry;
  end

  assign head      = mem_q[rd_ptr_q];
  assign log_valid = (occ_q != '0);
  assign log_va    = log_valid ? head.va    : '0;
  assign log_is_wr = log_valid ? head.is_wr : 1'b0;
  assign log_seq   = log_valid ? head.seq   : '0;
  assign log_count = occ_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_vtp_fail_log_fifo.sv
`timescale 1ns/1ps
// Bench for vtp_fail_log_fifo: two instances (CNT_WIDTH 16 and 4) share one stimulus stream
// and one queue-based reference model; directed scenarios plus a randomized phase.
module tb_vtp_fail_log_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_fail_valid, wr_fail_valid, clear, log_rd_en;
  logic [63:0] rd_fail_va, wr_fail_va;

  logic        a_valid, b_valid, a_is_wr, b_is_wr;
  logic [63:0] a_va, b_va;
  logic [15:0] a_seq, a_drop;
  logic [3:0]  b_seq, b_drop;
  logic [4:0]  a_count, b_count;

  vtp_fail_log_fifo #(.DEPTH(DEPTH), .VA_WIDTH(64), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .reset(reset),
    .rd_fail_valid(rd_fail_valid), .rd_fail_va(rd_fail_va),
    .wr_fail_valid(wr_fail_valid), .wr_fail_va(wr_fail_va),
    .clear(clear), .log_rd_en(log_rd_en),
    .log_valid(a_valid), .log_va(a_va), .log_is_wr(a_is_wr), .log_seq(a_seq),
    .log_count(a_count), .drop_cnt(a_drop)
  );

  vtp_fail_log_fifo #(.DEPTH(DEPTH), .VA_WIDTH(64), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .rd_fail_valid(rd_fail_valid), .rd_fail_va(rd_fail_va),
    .wr_fail_valid(wr_fail_valid), .wr_fail_va(wr_fail_va),
    .clear(clear), .log_rd_en(log_rd_en),
    .log_valid(b_valid), .log_va(b_va), .log_is_wr(b_is_wr), .log_seq(b_seq),
    .log_count(b_count), .drop_cnt(b_drop)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] va;
    bit          is_wr;
    int unsigned seq;
  } ent_t;

  ent_t        mq[$];
  int unsigned mseq;
  int unsigned mdrop;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mseq  = 0;
    mdrop = 0;
  endtask

  // One clock edge of the log, from the rules: clear wins; otherwise the pop frees a slot,
  // then rd and wr are admitted in order while space remains; seq counts every event.
  task automatic model_step(input bit rv, input logic [63:0] rva, input bit wv,
                            input logic [63:0] wva, input bit clr, input bit pop);
    int free;
    ent_t e;
    if (clr) begin
      model_reset();
      return;
    end
    free = DEPTH - mq.size();
    if (pop && mq.size() > 0) begin
      void'(mq.pop_front());
      free++;
    end
    if (rv) begin
      if (free > 0) begin
        e.va = rva; e.is_wr = 1'b0; e.seq = mseq;
        mq.push_back(e);
        free--;
      end else mdrop++;
      mseq++;
    end
    if (wv) begin
      if (free > 0) begin
        e.va = wva; e.is_wr = 1'b1; e.seq = mseq;
        mq.push_back(e);
        free--;
      end else mdrop++;
      mseq++;
    end
  endtask

  task automatic check_all();
    logic [63:0] ev;
    bit          ew;
    int unsigned es;
    bit          evld;
    evld = (mq.size() != 0);
    ev   = evld ? mq[0].va    : 64'h0;
    ew   = evld ? mq[0].is_wr : 1'b0;
    es   = evld ? mq[0].seq   : 0;
    chk("a_valid", 64'(a_valid), 64'(evld));
    chk("a_va",    a_va, ev);
    chk("a_is_wr", 64'(a_is_wr), 64'(ew));
    chk("a_seq",   64'(a_seq), 64'(es % 65536));
    chk("a_count", 64'(a_count), 64'(mq.size()));
    chk("a_drop",  64'(a_drop), 64'((mdrop > 65535) ? 65535 : mdrop));
    chk("b_valid", 64'(b_valid), 64'(evld));
    chk("b_va",    b_va, ev);
    chk("b_is_wr", 64'(b_is_wr), 64'(ew));
    chk("b_seq",   64'(b_seq), 64'(es % 16));
    chk("b_count", 64'(b_count), 64'(mq.size()));
    chk("b_drop",  64'(b_drop), 64'((mdrop > 15) ? 15 : mdrop));
  endtask

  // Drive one cycle's inputs (called just after a negedge), advance the model,
  // then compare at the next negedge.
  task automatic step(input bit rv, input logic [63:0] rva, input bit wv,
                      input logic [63:0] wva, input bit clr, input bit pop);
    rd_fail_valid = rv;  rd_fail_va = rva;
    wr_fail_valid = wv;  wr_fail_va = wva;
    clear = clr;         log_rd_en = pop;
    model_step(rv, rva, wv, wva, clr, pop);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    rd_fail_valid = 0; wr_fail_valid = 0; clear = 0; log_rd_en = 0;
    rd_fail_va = 0; wr_fail_va = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    chk("rst_valid", 64'(a_valid), 64'd0);
    chk("rst_count", 64'(a_count), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: single rd event visible next cycle, then popped
    step(1, 64'h1000, 0, 0, 0, 0);
    chk("t1_valid", 64'(a_valid), 64'd1);
    chk("t1_va",    a_va, 64'h1000);
    chk("t1_is_wr", 64'(a_is_wr), 64'd0);
    chk("t1_seq",   64'(a_seq), 64'd0);
    chk("t1_count", 64'(a_count), 64'd1);
    step(0, 0, 0, 0, 0, 1);
    chk("t1_pop_valid", 64'(a_valid), 64'd0);

    // 2: rd and wr in the same cycle
    step(0, 0, 0, 0, 1, 0);
    step(1, 64'hA0, 1, 64'hB0, 0, 0);
    chk("t2_count", 64'(a_count), 64'd2);
    chk("t2_va0",   a_va, 64'hA0);
    chk("t2_seq0",  64'(a_seq), 64'd0);
    step(0, 0, 0, 0, 0, 1);
    chk("t2_va1",   a_va, 64'hB0);
    chk("t2_wr1",   64'(a_is_wr), 64'd1);
    chk("t2_seq1",  64'(a_seq), 64'd1);

    // 3: fill, overflow by 3, drain in seq order
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 19; i++) step(1, 64'h2000 + 64'(i), 0, 0, 0, 0);
    chk("t3_count", 64'(a_count), 64'd16);
    chk("t3_drop",  64'(a_drop), 64'd3);
    for (int i = 0; i < 16; i++) begin
      chk("t3_seq", 64'(a_seq), 64'(i));
      step(0, 0, 0, 0, 0, 1);
    end

    // 4a: 15 entries, rd+wr with pop -> both accepted
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 15; i++) step(1, 64'h3000 + 64'(i), 0, 0, 0, 0);
    step(1, 64'h3100, 1, 64'h3200, 0, 1);
    chk("t4a_count", 64'(a_count), 64'd16);
    chk("t4a_drop",  64'(a_drop), 64'd0);
    // 4b: same without pop -> wr dropped
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 15; i++) step(1, 64'h3000 + 64'(i), 0, 0, 0, 0);
    step(1, 64'h3100, 1, 64'h3200, 0, 0);
    chk("t4b_count", 64'(a_count), 64'd16);
    chk("t4b_drop",  64'(a_drop), 64'd1);

    // 5: saturation on the 4-bit instance and seq wrap
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 36; i++) step(1, 64'h4000 + 64'(i), 0, 0, 0, 0);
    chk("t5_drop16", 64'(a_drop), 64'd20);
    chk("t5_drop4",  64'(b_drop), 64'd15);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, 1);
    step(1, 64'h4444, 0, 0, 0, 0);
    chk("t5_seq4",  64'(b_seq), 64'd4);
    chk("t5_seq16", 64'(a_seq), 64'd36);

    // 6: clear beats event and pop
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 64'h5000 + 64'(i), 0, 0, 0, 0);
    step(1, 64'h5555, 0, 0, 1, 1);
    chk("t6_count", 64'(a_count), 64'd0);
    chk("t6_drop",  64'(a_drop), 64'd0);
    step(1, 64'h6000, 0, 0, 0, 0);
    chk("t6_seq",   64'(a_seq), 64'd0);
    // async reset mid-fill, checked before any clock edge
    for (int i = 0; i < 4; i++) step(1, 64'h7000 + 64'(i), 1, 64'h7100 + 64'(i), 0, 0);
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("t6_arst_va", a_va, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    idle();

    // randomized phase
    for (int n = 0; n < 3000; n++) begin
      bit rv, wv, cl, pp;
      rv = ($urandom_range(0, 99) < 45);
      wv = ($urandom_range(0, 99) < 35);
      pp = ($urandom_range(0, 99) < ((n / 500) % 2 == 0 ? 60 : 25));
      cl = ($urandom_range(0, 299) == 0);
      step(rv, {$urandom, $urandom}, wv, {$urandom, $urandom}, cl, pp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
